// File: rtl/wb_ram_bist_master.sv
// -----------------------------------------------------------------------------
// wb_ram_bist_master
//
// Wishbone initiator that tests a RAM-backed Wishbone slave. It writes a
// seeded pattern to NUM_WORDS consecutive words, reads every word back,
// compares it with the pattern and reports pass/fail plus error statistics.
//
// Pattern for word index i (16 bits): P(i) = seed ^ {~i, i}.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   start_i, seed_i      run request (ignored while busy) and pattern seed
//   busy_o, done_o       run in progress / run finished (held until restart)
//   pass_o, timeout_o    result flags, valid while done_o
//   err_count_o          mismatching words, saturating
//   first_err_idx_o      index of first mismatch, 16'hFFFF when none
//   wbm_*                Wishbone master port (cyc/stb/we/sel/adr/dat_o,
//                        dat_i/ack_i)
// -----------------------------------------------------------------------------
module wb_ram_bist_master #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned NUM_WORDS = 512,
   parameter int unsigned ADR_SHIFT = 0,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   input  logic [31:0] seed_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic        timeout_o,
   output logic [15:0] err_count_o,
   output logic [15:0] first_err_idx_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] NO_ERR   = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_GAP,
      S_RD_REQ,
      S_RD_GAP,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic [31:0] seed_q, seed_d;
   logic [15:0] tmo_q, tmo_d;
   logic [15:0] err_q, err_d;
   logic [15:0] first_q, first_d;
   logic        pass_q, pass_d;
   logic        timeout_q, timeout_d;

   function automatic logic [31:0] pattern(input logic [31:0] seed,
                                           input logic [15:0] idx);
      return seed ^ {~idx, idx};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // State and status registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         seed_q    <= '0;
         tmo_q     <= '0;
         err_q     <= '0;
         first_q   <= NO_ERR;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         seed_q    <= seed_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         first_q   <= first_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state and bus outputs
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      seed_d    = seed_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      first_d   = first_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;

      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_we_o  = 1'b0;
      wbm_sel_o = 4'h0;
      wbm_adr_o = '0;
      wbm_dat_o = '0;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               seed_d    = seed_i;
               idx_d     = '0;
               tmo_d     = '0;
               err_d     = '0;
               first_d   = NO_ERR;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               state_d   = S_WR_REQ;
            end
         end

         S_WR_REQ, S_RD_REQ: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_sel_o = 4'hF;
            wbm_adr_o = BASE_ADDR | (32'(idx_q) << ADR_SHIFT);
            if (state_q == S_WR_REQ) begin
               wbm_we_o  = 1'b1;
               wbm_dat_o = pattern(seed_q, idx_q);
            end
            // An ack in the final allowed cycle still completes the transfer.
            if (wbm_ack_i) begin
               if (state_q == S_RD_REQ) begin
                  state_d = S_RD_GAP;
                  if (wbm_dat_i != pattern(seed_q, idx_q)) begin
                     err_d = sat_inc(err_q);
                     if (first_q == NO_ERR) begin
                        first_d = idx_q;
                     end
                  end
               end else begin
                  state_d = S_WR_GAP;
               end
            end else if (tmo_q == TMO_LAST) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = S_DONE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end

         // One idle cycle with stb low so slaves gating on their own
         // registered ack never see a back-to-back strobe.
         S_WR_GAP, S_RD_GAP: begin
            tmo_d = '0;
            if (idx_q == LAST_IDX) begin
               idx_d = '0;
               if (state_q == S_WR_GAP) begin
                  state_d = S_RD_REQ;
               end else begin
                  pass_d  = (err_q == 16'd0);
                  state_d = S_DONE;
               end
            end else begin
               idx_d   = idx_q + 16'd1;
               state_d = (state_q == S_WR_GAP) ? S_WR_REQ : S_RD_REQ;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy_o          = (state_q == S_WR_REQ) || (state_q == S_WR_GAP) ||
                            (state_q == S_RD_REQ) || (state_q == S_RD_GAP);
   assign done_o          = (state_q == S_DONE);
   assign pass_o          = pass_q;
   assign timeout_o       = timeout_q;
   assign err_count_o     = err_q;
   assign first_err_idx_o = first_q;

endmodule
